load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 228 ++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding CPU load/store engine for a word-wide,
// little-endian data memory. Byte and halfword stores are done as
// read-modify-write. Misaligned, out-of-range and illegal-size requests
// get an error response without touching memory.
//
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   req_valid/req_ready               request handshake (ready only in IDLE)
//   req_write, req_size, req_unsigned request kind, size, load extension
//   req_addr, req_wdata               byte address, right-justified store data
//   resp_valid, resp_err, resp_rdata  one-cycle registered response
//   mem_read, mem_write               memory strobes (registered)
//   mem_address, mem_write_data       word-aligned address, write word
//   mem_read_data                     combinational read word from memory
module load_store_unit #(
   parameter int MEM_BYTES = 16384
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic        resp_err,
   output logic [31:0] resp_rdata,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_address,
   output logic [31:0] mem_write_data,
   input  logic [31:0] mem_read_data
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_READ  = 2'd1;
   localparam logic [1:0] ST_WRITE = 2'd2;
   localparam logic [1:0] ST_RESP  = 2'd3;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

   // Select the addressed lane of a memory word and extend it to 32 bits.
   function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [1:0]  size,
                                                input logic [1:0]  lo,
                                                input logic        uns);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      b = word[{lo, 3'b000} +: 8];
      h = lo[1] ? word[31:16] : word[15:0];
      case (size)
         SZ_BYTE: r = {{24{~uns & b[7]}}, b};
         SZ_HALF: r = {{16{~uns & h[15]}}, h};
         default: r = word;
      endcase
      return r;
   endfunction

   // Replace only the addressed lane(s) of a memory word with store data.
   function automatic logic [31:0] store_merge(input logic [31:0] word,
                                               input logic [31:0] wd,
                                               input logic [1:0]  size,
                                               input logic [1:0]  lo);
      logic [31:0] r;
      r = word;
      case (size)
         SZ_BYTE: r[{lo, 3'b000} +: 8] = wd[7:0];
         SZ_HALF: begin
            if (lo[1]) r[31:16] = wd[15:0];
            else       r[15:0]  = wd[15:0];
         end
         default: r = wd;
      endcase
      return r;
   endfunction

   logic [1:0]  state_q, state_d;
   logic        write_q, write_d;
   logic [1:0]  size_q, size_d;
   logic        unsigned_q, unsigned_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        ready_q, ready_d;
   logic        resp_valid_q, resp_valid_d;
   logic        resp_err_q, resp_err_d;
   logic [31:0] resp_rdata_q, resp_rdata_d;
   logic        mem_read_q, mem_read_d;
   logic        mem_write_q, mem_write_d;
   logic [31:0] mem_address_q, mem_address_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic        req_err_s;

   // Classify the incoming request as erroneous (size, alignment, range).
   always_comb begin
      req_err_s = 1'b0;
      case (req_size)
         SZ_BYTE: req_err_s = 1'b0;
         SZ_HALF: req_err_s = req_addr[0];
         SZ_WORD: req_err_s = |req_addr[1:0];
         default: req_err_s = 1'b1;
      endcase
      if (req_addr >= MEM_LIMIT) req_err_s = 1'b1;
      else                       req_err_s = req_err_s;
   end

   // Next-state and next-output logic; all outputs are computed one cycle
   // ahead so every port is driven straight from a flop.
   always_comb begin
      state_d       = state_q;
      write_d       = write_q;
      size_d        = size_q;
      unsigned_d    = unsigned_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      ready_d       = 1'b0;
      resp_valid_d  = 1'b0;
      resp_err_d    = 1'b0;
      resp_rdata_d  = 32'h0;
      mem_read_d    = 1'b0;
      mem_write_d   = 1'b0;
      mem_address_d = 32'h0;
      mem_wdata_d   = 32'h0;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               write_d    = req_write;
               size_d     = req_size;
               unsigned_d = req_unsigned;
               addr_d     = req_addr;
               wdata_d    = req_wdata;
               if (req_err_s) begin
                  state_d      = ST_RESP;
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
               end else if (!req_write || (req_size != SZ_WORD)) begin
                  // Loads and sub-word stores both start with a read.
                  state_d       = ST_READ;
                  mem_read_d    = 1'b1;
                  mem_address_d = {req_addr[31:2], 2'b00};
               end else begin
                  state_d       = ST_WRITE;
                  mem_write_d   = 1'b1;
                  mem_address_d = {req_addr[31:2], 2'b00};
                  mem_wdata_d   = req_wdata;
               end
            end else begin
               ready_d = 1'b1;
            end
         end
         ST_READ: begin
            if (write_q) begin
               state_d       = ST_WRITE;
               mem_write_d   = 1'b1;
               mem_address_d = {addr_q[31:2], 2'b00};
               mem_wdata_d   = store_merge(mem_read_data, wdata_q, size_q, addr_q[1:0]);
            end else begin
               state_d      = ST_RESP;
               resp_valid_d = 1'b1;
               resp_rdata_d = load_extend(mem_read_data, size_q, addr_q[1:0], unsigned_q);
            end
         end
         ST_WRITE: begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
         end
         ST_RESP: begin
            state_d = ST_IDLE;
            ready_d = 1'b1;
         end
         default: begin
            state_d = ST_IDLE;
            ready_d = 1'b1;
         end
      endcase
   end

   // State and output registers; reset aborts any access in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         write_q       <= 1'b0;
         size_q        <= 2'b00;
         unsigned_q    <= 1'b0;
         addr_q        <= 32'h0;
         wdata_q       <= 32'h0;
         ready_q       <= 1'b1;
         resp_valid_q  <= 1'b0;
         resp_err_q    <= 1'b0;
         resp_rdata_q  <= 32'h0;
         mem_read_q    <= 1'b0;
         mem_write_q   <= 1'b0;
         mem_address_q <= 32'h0;
         mem_wdata_q   <= 32'h0;
      end else begin
         state_q       <= state_d;
         write_q       <= write_d;
         size_q        <= size_d;
         unsigned_q    <= unsigned_d;
         addr_q        <= addr_d;
         wdata_q       <= wdata_d;
         ready_q       <= ready_d;
         resp_valid_q  <= resp_valid_d;
         resp_err_q    <= resp_err_d;
         resp_rdata_q  <= resp_rdata_d;
         mem_read_q    <= mem_read_d;
         mem_write_q   <= mem_write_d;
         mem_address_q <= mem_address_d;
         mem_wdata_q   <= mem_wdata_d;
      end
   end

   assign req_ready      = ready_q;
   assign resp_valid     = resp_valid_q;
   assign resp_err       = resp_err_q;
   assign resp_rdata     = resp_rdata_q;
   assign mem_read       = mem_read_q;
   assign mem_write      = mem_write_q;
   assign mem_address    = mem_address_q;
   assign mem_write_data = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small word memory model.
module tb_load_store_unit;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_err;
   logic [31:0] resp_rdata;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_address;
   logic [31:0] mem_write_data;
   logic [31:0] mem_read_data;

   logic [31:0] mem [0:63];
   logic        init_mem;
   int          rd_cnt;
   int          wr_cnt;
   int          both_cnt;
   logic [31:0] last_waddr;
   logic [31:0] last_wdata;

   int checks;
   int errors;

   load_store_unit #(.MEM_BYTES(16384)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
      .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
      .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign mem_read_data = mem_read ? mem[mem_address[7:2]] : 32'h0;

   // Memory model plus strobe counters.
   always @(posedge clk) begin
      if (init_mem) begin
         for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
         mem[8]  <= 32'h8001FF80;
         mem[63] <= 32'h9A000000;
      end else if (mem_write) begin
         mem[mem_address[7:2]] <= mem_write_data;
      end
      if (mem_write) begin
         wr_cnt     <= wr_cnt + 1;
         last_waddr <= mem_address;
         last_wdata <= mem_write_data;
      end
      if (mem_read) rd_cnt <= rd_cnt + 1;
      if (mem_read && mem_write) both_cnt <= both_cnt + 1;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   typedef struct {
      string       name;
      logic        write;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        err;
      logic [31:0] rdata;
      int          lat;
      int          nrd;
      int          nwr;
      logic [31:0] wword;
   } vec_t;

   vec_t vecs[$];

   task automatic run_vec(input vec_t v);
      int lat;
      int rd0;
      int wr0;
      @(negedge clk);
      chk({v.name, ".ready"}, {31'h0, req_ready}, 32'h1);
      req_valid    = 1'b1;
      req_write    = v.write;
      req_size     = v.size;
      req_unsigned = v.uns;
      req_addr     = v.addr;
      req_wdata    = v.wdata;
      rd0 = rd_cnt;
      wr0 = wr_cnt;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      lat = 1;
      while (!resp_valid && lat < 8) begin
         @(negedge clk);
         lat++;
      end
      chk({v.name, ".lat"}, 32'(lat), 32'(v.lat));
      chk({v.name, ".err"}, {31'h0, resp_err}, {31'h0, v.err});
      chk({v.name, ".rdata"}, resp_rdata, v.rdata);
      chk({v.name, ".nrd"}, 32'(rd_cnt - rd0), 32'(v.nrd));
      chk({v.name, ".nwr"}, 32'(wr_cnt - wr0), 32'(v.nwr));
      if (v.nwr != 0) begin
         chk({v.name, ".waddr"}, last_waddr, {v.addr[31:2], 2'b00});
         chk({v.name, ".wword"}, last_wdata, v.wword);
      end else begin
         chk({v.name, ".noresp_idle"}, {31'h0, req_ready}, 32'h0);
      end
   endtask

   task automatic add(input string n, input logic w, input logic [1:0] s, input logic u,
                      input logic [31:0] a, input logic [31:0] wd, input logic e,
                      input logic [31:0] rd, input int lat, input int nrd, input int nwr,
                      input logic [31:0] ww);
      vec_t v;
      v.name = n; v.write = w; v.size = s; v.uns = u; v.addr = a; v.wdata = wd;
      v.err = e; v.rdata = rd; v.lat = lat; v.nrd = nrd; v.nwr = nwr; v.wword = ww;
      vecs.push_back(v);
   endtask

   logic [5:0] busy_exp [0:5];

   initial begin
      checks = 0; errors = 0;
      rd_cnt = 0; wr_cnt = 0; both_cnt = 0;
      last_waddr = 32'h0; last_wdata = 32'h0;
      req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
      req_addr = 32'h0; req_wdata = 32'h0;
      init_mem = 1'b1;
      rst_n = 1'b0;

      //   name          w     sz     u     addr          wdata         err   rdata         lat nrd nwr wword
      add("st_w_10",    1'b1, 2'd2, 1'b0, 32'h10,   32'hDEADBEEF, 1'b0, 32'h0,        2, 0, 1, 32'hDEADBEEF);
      add("ld_w_10",    1'b0, 2'd2, 1'b0, 32'h10,   32'h0,        1'b0, 32'hDEADBEEF, 2, 1, 0, 32'h0);
      add("st_b_12",    1'b1, 2'd0, 1'b0, 32'h12,   32'hAAAAAA7F, 1'b0, 32'h0,        3, 1, 1, 32'hDE7FBEEF);
      add("ld_w_10b",   1'b0, 2'd2, 1'b0, 32'h10,   32'h0,        1'b0, 32'hDE7FBEEF, 2, 1, 0, 32'h0);
      add("ld_b_20s",   1'b0, 2'd0, 1'b0, 32'h20,   32'h0,        1'b0, 32'hFFFFFF80, 2, 1, 0, 32'h0);
      add("ld_b_20u",   1'b0, 2'd0, 1'b1, 32'h20,   32'h0,        1'b0, 32'h00000080, 2, 1, 0, 32'h0);
      add("ld_h_22s",   1'b0, 2'd1, 1'b0, 32'h22,   32'h0,        1'b0, 32'hFFFF8001, 2, 1, 0, 32'h0);
      add("ld_h_22u",   1'b0, 2'd1, 1'b1, 32'h22,   32'h0,        1'b0, 32'h00008001, 2, 1, 0, 32'h0);
      add("ld_b_21s",   1'b0, 2'd0, 1'b0, 32'h21,   32'h0,        1'b0, 32'hFFFFFFFF, 2, 1, 0, 32'h0);
      add("ld_b_22s",   1'b0, 2'd0, 1'b0, 32'h22,   32'h0,        1'b0, 32'h00000001, 2, 1, 0, 32'h0);
      add("ld_h_20s",   1'b0, 2'd1, 1'b0, 32'h20,   32'h0,        1'b0, 32'hFFFFFF80, 2, 1, 0, 32'h0);
      add("st_h_12",    1'b1, 2'd1, 1'b0, 32'h12,   32'hFFFF1234, 1'b0, 32'h0,        3, 1, 1, 32'h1234BEEF);
      add("st_b_13",    1'b1, 2'd0, 1'b0, 32'h13,   32'h00000055, 1'b0, 32'h0,        3, 1, 1, 32'h5534BEEF);
      add("st_b_10",    1'b1, 2'd0, 1'b0, 32'h10,   32'h00000011, 1'b0, 32'h0,        3, 1, 1, 32'h5534BE11);
      add("ld_w_10c",   1'b0, 2'd2, 1'b0, 32'h10,   32'h0,        1'b0, 32'h5534BE11, 2, 1, 0, 32'h0);
      add("err_h_21",   1'b0, 2'd1, 1'b0, 32'h21,   32'h0,        1'b1, 32'h0,        1, 0, 0, 32'h0);
      add("err_w_4002", 1'b1, 2'd2, 1'b0, 32'h4002, 32'h12345678, 1'b1, 32'h0,        1, 0, 0, 32'h0);
      add("err_sz11",   1'b0, 2'd3, 1'b0, 32'h10,   32'h0,        1'b1, 32'h0,        1, 0, 0, 32'h0);
      add("err_w_4000", 1'b0, 2'd2, 1'b0, 32'h4000, 32'h0,        1'b1, 32'h0,        1, 0, 0, 32'h0);
      add("err_sb_4000",1'b1, 2'd0, 1'b0, 32'h4000, 32'h000000AB, 1'b1, 32'h0,        1, 0, 0, 32'h0);
      add("ld_b_3fff",  1'b0, 2'd0, 1'b1, 32'h3FFF, 32'h0,        1'b0, 32'h0000009A, 2, 1, 0, 32'h0);

      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs",
          {25'h0, req_ready, resp_valid, resp_err, mem_read, mem_write, |mem_address, |mem_write_data},
          {25'h0, 1'b1, 6'b000000});
      chk("reset_rdata", resp_rdata, 32'h0);
      @(negedge clk);
      init_mem = 1'b0;
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

      // Reset during the READ phase of a byte store must abort it.
      begin
         int wr0;
         @(negedge clk);
         wr0 = wr_cnt;
         req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
         req_addr = 32'h11; req_wdata = 32'h000000CC;
         @(posedge clk);
         @(negedge clk);
         req_valid = 1'b0;
         chk("rst_mid.in_read", {31'h0, mem_read}, 32'h1);
         rst_n = 1'b0;
         #1;
         chk("rst_mid.ready", {31'h0, req_ready}, 32'h1);
         chk("rst_mid.strobes", {29'h0, mem_read, mem_write, resp_valid}, 32'h0);
         repeat (2) @(posedge clk);
         @(negedge clk);
         chk("rst_mid.resp", {31'h0, resp_valid}, 32'h0);
         rst_n = 1'b1;
         repeat (2) @(negedge clk);
         chk("rst_mid.nwr", 32'(wr_cnt - wr0), 32'h0);
         chk("rst_mid.mem", mem[4], 32'h5534BE11);
      end

      // First request after reset release is accepted immediately.
      begin
         vec_t v;
         v.name = "post_rst_ld"; v.write = 1'b0; v.size = 2'd2; v.uns = 1'b0;
         v.addr = 32'h10; v.wdata = 32'h0; v.err = 1'b0; v.rdata = 32'h5534BE11;
         v.lat = 2; v.nrd = 1; v.nwr = 0; v.wword = 32'h0;
         run_vec(v);
      end

      // req_valid held high: second accept only after the IDLE cycle.
      busy_exp[0] = {1'b0, 1'b0, 4'h0};
      busy_exp[1] = {1'b0, 1'b1, 4'h0};
      busy_exp[2] = {1'b1, 1'b0, 4'h0};
      busy_exp[3] = {1'b0, 1'b0, 4'h0};
      busy_exp[4] = {1'b0, 1'b1, 4'h0};
      busy_exp[5] = {1'b1, 1'b0, 4'h0};
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_size = 2'd0; req_unsigned = 1'b1;
      req_addr = 32'h20; req_wdata = 32'h0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (c == 4) req_valid = 1'b0;
         chk($sformatf("busy.cyc%0d", c), {26'h0, req_ready, resp_valid, 4'h0},
             {26'h0, busy_exp[c]});
         if (resp_valid) chk($sformatf("busy.rdata%0d", c), resp_rdata, 32'h00000080);
      end

      chk("never_both_strobes", 32'(both_cnt), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1);
   end

endmodule
